// File: rtl/divisor_secuencial_4b.sv
// -----------------------------------------------------------------------------
// divisor_secuencial_4b
//
// Sequential restoring divider. A start pulse latches an unsigned num/den pair.
// The divider then produces one quotient bit per clock for WIDTH clocks. A
// single-cycle done pulse reports quotient (result), remainder (rest) and the
// divide-by-zero flag.
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous, active-high reset
//   start     in   1      begin a division; accepted in IDLE or DONE only
//   num       in   WIDTH  dividend, unsigned
//   den       in   WIDTH  divisor, unsigned
//   busy      out  1      high while iterating (CALC state)
//   done      out  1      one-cycle pulse; result/rest/div_zero updated
//   result    out  WIDTH  quotient, held until next done
//   rest      out  WIDTH  remainder, held until next done
//   div_zero  out  1      den was 0 for the operation last reported
//
// Handshake: start is sampled on a clock edge. It is acted upon only when busy
// is low (IDLE or DONE). The outputs result/rest/div_zero are valid from the
// cycle where done=1 until the next done pulse or reset.
//
// Timing: start is sampled at edge k. busy is high after edges k..k+WIDTH-1.
// done is high after edge k+WIDTH. Latency does not depend on the data. A start
// arriving during the done cycle chains the next operation with no idle gap.
// -----------------------------------------------------------------------------
module divisor_secuencial_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rest,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] q;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] d;      // latched divisor
  logic [WIDTH:0]   r;      // partial remainder, one guard bit
  logic [CW-1:0]    cnt;    // iterations still to run

  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last_iter;

  // One restoring step: shift the next dividend bit into the remainder.
  // Subtract the divisor when the remainder can take it.
  always_comb begin
    t     = {r[WIDTH-1:0], q[WIDTH-1]};
    ge    = (t >= {1'b0, d});
    r_nxt = ge ? (t - {1'b0, d}) : t;
    q_nxt = {q[WIDTH-2:0], ge};
  end

  assign last_iter = (cnt == CW'(1));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // ---------------------------------------------------------------------------
  // Datapath. The results are loaded on the final iteration, so they are
  // already valid in the cycle where done is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      d        <= '0;
      r        <= '0;
      cnt      <= '0;
      result   <= '0;
      rest     <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            q   <= num;
            d   <= den;
            r   <= '0;
            cnt <= CW'(WIDTH);
          end
        end
        CALC: begin
          q   <= q_nxt;
          r   <= r_nxt;
          cnt <= cnt - CW'(1);
          if (last_iter) begin
            result   <= q_nxt;
            rest     <= r_nxt[WIDTH-1:0];
            div_zero <= (d == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_secuencial_4b.sv
// -----------------------------------------------------------------------------
// tb_divisor_secuencial_4b
//
// Self-checking bench for divisor_secuencial_4b with WIDTH=4. Each accepted
// operation pushes its expected {div_zero, result, rest} onto exp_q. A monitor
// pops exp_q and compares it on every done pulse.
// -----------------------------------------------------------------------------
module tb_divisor_secuencial_4b;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] num;
  logic [W-1:0] den;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] rest;
  logic         div_zero;

  int n_vec;
  int n_err;
  int done_cnt;

  logic [2*W:0] exp_q[$];

  divisor_secuencial_4b #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num      (num),
    .den      (den),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rest     (rest),
    .div_zero (div_zero)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking task
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: long division with the divide-by-zero convention.
  function automatic logic [2*W:0] model(input logic [W-1:0] n, input logic [W-1:0] d);
    if (d == 0) return {1'b1, {W{1'b1}}, n};
    return {1'b0, W'(n / d), W'(n % d)};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: samples on the falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("busy_low_in_done", busy, 0);
      if (exp_q.size() == 0) begin
        check("pending_on_done", exp_q.size(), 1);
      end else begin
        logic [2*W:0] e;
        e = exp_q.pop_front();
        check("result", result, e[2*W-1:W]);
        check("rest", rest, e[W-1:0]);
        check("div_zero", div_zero, e[2*W]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Call this task at a falling edge. It returns at the falling edge where done
  // is observed high, which is the DONE cycle.
  task automatic wait_done(input bit chk_lat, input int lat0);
    int lat;
    lat = lat0;
    while (!done && lat < 20) begin
      if (chk_lat) check("busy_during_calc", busy, 1);
      @(negedge clk);
      lat++;
    end
    check("done_seen", done, 1);
    if (chk_lat) check("latency", lat, W + 1);
  endtask

  task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d, input bit chk_lat);
    start = 1'b1;
    num   = n;
    den   = d;
    exp_q.push_back(model(n, d));
    @(negedge clk);
    start = 1'b0;
    num   = W'($urandom_range(0, 15));
    den   = W'($urandom_range(0, 15));
    wait_done(chk_lat, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int dc;
    n_vec    = 0;
    n_err    = 0;
    done_cnt = 0;
    rst   = 1'b1;
    start = 1'b1;
    num   = 4'd9;
    den   = 4'd2;
    idle_cycles(3);
    // Reset takes priority over start.
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_rest", rest, 0);
    check("rst_div_zero", div_zero, 0);
    rst   = 1'b0;
    start = 1'b0;
    idle_cycles(2);

    // Basic operation and divide by zero
    do_op(4'd13, 4'd4, 1'b1);
    idle_cycles(1);
    do_op(4'd7, 4'd0, 1'b1);
    idle_cycles(1);

    // Boundary values. The 15/1 then 9/9 pair clears the div_zero flag.
    do_op(4'd15, 4'd1, 1'b1);  idle_cycles(1);
    do_op(4'd3, 4'd9, 1'b1);   idle_cycles(1);
    do_op(4'd0, 4'd5, 1'b1);   idle_cycles(1);
    do_op(4'd15, 4'd15, 1'b1); idle_cycles(1);
    do_op(4'd7, 4'd0, 1'b1);   idle_cycles(1);
    do_op(4'd9, 4'd9, 1'b1);   idle_cycles(2);
    check("outputs_held", {result, rest}, {4'd1, 4'd0});

    // A start pulse while busy is ignored
    dc    = done_cnt;
    start = 1'b1; num = 4'd12; den = 4'd5;
    exp_q.push_back(model(4'd12, 4'd5));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; num = 4'd2; den = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 3);
    idle_cycles(10);
    check("single_done", done_cnt - dc, 1);

    // Reset during the second CALC cycle aborts the operation
    dc    = done_cnt;
    start = 1'b1; num = 4'd14; den = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_rest", rest, 0);
    check("abort_div_zero", div_zero, 0);
    idle_cycles(10);
    check("abort_no_done", done_cnt - dc, 0);
    do_op(4'd14, 4'd3, 1'b1);
    idle_cycles(1);

    // Back-to-back operation: start is accepted in the DONE cycle
    do_op(4'd10, 4'd3, 1'b1);
    do_op(4'd11, 4'd2, 1'b1);
    idle_cycles(1);

    // Exhaustive sweep of every num/den pair
    for (int n = 0; n < 16; n++) begin
      for (int d = 0; d < 16; d++) begin
        do_op(W'(n), W'(d), 1'b0);
        idle_cycles(1);
      end
    end

    idle_cycles(3);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
